// File: rtl/pulse_path_filter_pkg.sv
// Shared types for the pulse path filter: output value encoding, queue entry and depth.
package pulse_path_filter_pkg;

  localparam int         QDEPTH = 4;
  localparam logic [2:0] QFULL  = 3'(QDEPTH);

  typedef enum logic [1:0] {
    V0 = 2'd0,
    V1 = 2'd1,
    VX = 2'd2
  } val_t;

  typedef struct packed {
    val_t       value;
    logic [3:0] rem;
  } entry_t;

  function automatic logic [3:0] dec_sat(input logic [3:0] r);
    return (r == 4'd0) ? 4'd0 : r - 4'd1;
  endfunction

endpackage

// File: rtl/pulse_event_queue.sv
// Ordered 4-entry event queue; every stored countdown steps down once per cycle.
module pulse_event_queue
  import pulse_path_filter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pop_head,
  input  logic                  pop_tail,
  input  logic                  rewrite_tail,
  input  entry_t                tail_entry,
  input  logic                  push,
  input  entry_t                push_entry,
  output logic [2:0]            cnt,
  output entry_t [QDEPTH-1:0]   view
);

  entry_t [QDEPTH-1:0] ent;
  entry_t [QDEPTH-1:0] ent_nxt;
  logic   [2:0]        cnt_nxt;

  // view is the post-decrement image the classifier reasons about this cycle
  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      view[i]     = ent[i];
      view[i].rem = dec_sat(ent[i].rem);
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ent_nxt = view;
    cnt_nxt = cnt;
    if (pop_head) begin
      for (int i = 0; i < QDEPTH - 1; i++) ent_nxt[i] = ent_nxt[i+1];
      ent_nxt[QDEPTH-1] = '0;
      cnt_nxt = cnt_nxt - 3'd1;
    end
    if (pop_tail) cnt_nxt = cnt_nxt - 3'd1;
    if (rewrite_tail && cnt_nxt != 3'd0) ent_nxt[2'(cnt_nxt - 3'd1)] = tail_entry;
    if (push && cnt_nxt != QFULL) begin
      ent_nxt[2'(cnt_nxt)] = push_entry;
      cnt_nxt = cnt_nxt + 3'd1;
    end
  end

  // NOTE: the small entry store is reset along with the count so no stale entry survives reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent <= '0;
      cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      ent <= ent_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/pulse_path_filter.sv
// Transport-delay path model with pulse rejection, X windows and cancelled-pulse handling.
module pulse_path_filter
  import pulse_path_filter_pkg::*;
#(
  parameter int RISE_DLY       = 2,
  parameter int FALL_DLY       = 3,
  parameter int REJECT_LIM     = 1,
  parameter int ERROR_LIM      = 2,
  parameter int SHOW_CANCELLED = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic dout_x,
  output logic ovf
);

  logic                din_q;
  logic [2:0]          cnt;
  entry_t [QDEPTH-1:0] view;
  logic                ev;
  logic                due;
  logic [3:0]          dly;
  logic [2:0]          rcnt;
  logic [3:0]          tail_rem;
  logic [3:0]          prev_rem;
  val_t                new_val;
  val_t                cur_val;
  val_t                restored;
  int                  w;
  logic                pop_tail;
  logic                rewrite_tail;
  logic                push;
  logic                ovf_set;
  entry_t              tail_entry;
  entry_t              push_entry;

  assign ev      = din ^ din_q;
  assign dly     = din ? 4'(RISE_DLY) : 4'(FALL_DLY);
  assign new_val = din ? V1 : V0;
  assign cur_val = dout_x ? VX : (dout ? V1 : V0);
  assign due     = (cnt != 3'd0) && (view[0].rem == 4'd0);

  // The head pops before the event is judged, so the tail index itself never moves.
  assign rcnt     = cnt - {2'b00, due};
  assign tail_rem = view[2'(cnt - 3'd1)].rem;
  assign prev_rem = (rcnt >= 3'd2) ? view[2'(cnt - 3'd2)].rem : 4'd0;
  assign restored = (rcnt >= 3'd2) ? view[2'(cnt - 3'd2)].value
                                   : (due ? view[0].value : cur_val);

  always_comb begin
    w            = int'(dly) - int'(tail_rem);
    pop_tail     = 1'b0;
    rewrite_tail = 1'b0;
    push         = 1'b0;
    ovf_set      = 1'b0;
    tail_entry   = '0;
    push_entry   = '{value: new_val, rem: dly};
    if (ev) begin
      if (rcnt == 3'd0) begin
        push = 1'b1;
      end else if (w < 0) begin
        if (SHOW_CANCELLED == 0) begin
          pop_tail = 1'b1;
        end else begin
          rewrite_tail = 1'b1;
          tail_entry   = '{value: VX, rem: (dly > prev_rem) ? dly : prev_rem};
          push_entry   = '{value: restored, rem: tail_rem};
          push         = 1'b1;
        end
      end else if (w == 0 || w < REJECT_LIM) begin
        pop_tail = 1'b1;
      end else if (w < ERROR_LIM) begin
        rewrite_tail = 1'b1;
        tail_entry   = '{value: VX, rem: tail_rem};
        push         = 1'b1;
      end else begin
        push = 1'b1;
      end
      // A full queue drops the whole event, tail rewrite included, so no X is left stranded.
      if (push && rcnt == QFULL) begin
        push         = 1'b0;
        rewrite_tail = 1'b0;
        ovf_set      = 1'b1;
      end
    end
  end

  pulse_event_queue u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .pop_head     (due),
    .pop_tail     (pop_tail),
    .rewrite_tail (rewrite_tail),
    .tail_entry   (tail_entry),
    .push         (push),
    .push_entry   (push_entry),
    .cnt          (cnt),
    .view         (view)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q  <= 1'b0;
      dout   <= 1'b0;
      dout_x <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      din_q <= din;
      if (ovf_set) ovf <= 1'b1;
      if (due) begin
        case (view[0].value)
          V0:      begin dout <= 1'b0; dout_x <= 1'b0; end
          V1:      begin dout <= 1'b1; dout_x <= 1'b0; end
          default: dout_x <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_path_filter.sv
// Directed bench: five filter configurations share one clock; traces are bit-per-cycle vectors.
module tb_pulse_path_filter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] din;
  logic [4:0] dout;
  logic [4:0] dout_x;
  logic [4:0] ovf;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  pulse_path_filter u_def (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .dout(dout[0]), .dout_x(dout_x[0]), .ovf(ovf[0]));

  pulse_path_filter #(.RISE_DLY(3), .FALL_DLY(2), .REJECT_LIM(1), .ERROR_LIM(3)) u_xwin (
    .clk(clk), .rst_n(rst_n), .din(din[1]), .dout(dout[1]), .dout_x(dout_x[1]), .ovf(ovf[1]));

  pulse_path_filter #(.RISE_DLY(4), .FALL_DLY(1)) u_neg0 (
    .clk(clk), .rst_n(rst_n), .din(din[2]), .dout(dout[2]), .dout_x(dout_x[2]), .ovf(ovf[2]));

  pulse_path_filter #(.RISE_DLY(4), .FALL_DLY(1), .SHOW_CANCELLED(1)) u_neg1 (
    .clk(clk), .rst_n(rst_n), .din(din[3]), .dout(dout[3]), .dout_x(dout_x[3]), .ovf(ovf[3]));

  pulse_path_filter #(.RISE_DLY(8), .FALL_DLY(8), .REJECT_LIM(1), .ERROR_LIM(1)) u_ovf (
    .clk(clk), .rst_n(rst_n), .din(din[4]), .dout(dout[4]), .dout_x(dout_x[4]), .ovf(ovf[4]));

  task automatic do_reset();
    rst_n = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Bit c of pat is din as sampled at edge c after reset release; bit c of each
  // trace is the output observed just after edge c.
  task automatic run_trace(input int k, input logic [31:0] pat,
                           output logic [31:0] d_tr, output logic [31:0] x_tr,
                           output logic [31:0] o_tr);
    do_reset();
    d_tr = '0; x_tr = '0; o_tr = '0;
    d_tr[0] = dout[k]; x_tr[0] = dout_x[k]; o_tr[0] = ovf[k];
    for (int c = 1; c < 32; c++) begin
      din[k] = pat[c];
      @(posedge clk);
      #1;
      d_tr[c] = dout[k]; x_tr[c] = dout_x[k]; o_tr[c] = ovf[k];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din   = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({dout, dout_x, ovf} !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0000", {dout, dout_x, ovf});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rise_hold();
    logic [31:0] d_tr, x_tr, o_tr;
    run_trace(0, 32'hFFFF_FC00, d_tr, x_tr, o_tr);
    vectors++;
    if (d_tr !== 32'hFFFF_F000) begin
      miscompares++; $display("FAIL rise_hold_dout got %h want %h", d_tr, 32'hFFFF_F000);
    end
    vectors++;
    if (x_tr !== 32'h0) begin
      miscompares++; $display("FAIL rise_hold_x got %h want %h", x_tr, 32'h0);
    end
  endtask

  task automatic test_wide_pulse();
    logic [31:0] d_tr, x_tr, o_tr;
    run_trace(0, 32'h0000_3C00, d_tr, x_tr, o_tr);
    vectors++;
    if (d_tr !== 32'h0001_F000) begin
      miscompares++; $display("FAIL wide_pulse_dout got %h want %h", d_tr, 32'h0001_F000);
    end
    vectors++;
    if (x_tr !== 32'h0) begin
      miscompares++; $display("FAIL wide_pulse_x got %h want %h", x_tr, 32'h0);
    end
  endtask

  task automatic test_narrow_pulse();
    logic [31:0] d_tr, x_tr, o_tr;
    // w = 3 - 1 = 2 = ERROR_LIM: clean two-cycle pulse
    run_trace(0, 32'h0000_0400, d_tr, x_tr, o_tr);
    vectors++;
    if (d_tr !== 32'h0000_3000) begin
      miscompares++; $display("FAIL narrow_pulse_dout got %h want %h", d_tr, 32'h0000_3000);
    end
    vectors++;
    if (x_tr !== 32'h0) begin
      miscompares++; $display("FAIL narrow_pulse_x got %h want %h", x_tr, 32'h0);
    end
  endtask

  task automatic test_x_window();
    logic [31:0] d_tr, x_tr, o_tr;
    // two-cycle input: w = 2 - 1 = 1, inside [REJECT_LIM, ERROR_LIM) -> X then 0
    run_trace(1, 32'h0000_0C00, d_tr, x_tr, o_tr);
    vectors++;
    if (x_tr !== 32'h0000_2000) begin
      miscompares++; $display("FAIL xwin_x got %h want %h", x_tr, 32'h0000_2000);
    end
    vectors++;
    if (d_tr !== 32'h0) begin
      miscompares++; $display("FAIL xwin_dout got %h want %h", d_tr, 32'h0);
    end
    // one-cycle input: w = 2 - 2 = 0, dropped with no X
    run_trace(1, 32'h0000_0400, d_tr, x_tr, o_tr);
    vectors++;
    if ({d_tr, x_tr} !== 64'h0) begin
      miscompares++; $display("FAIL zero_width got %h want %h", {d_tr, x_tr}, 64'h0);
    end
    // fall event in the head's apply cycle: pop first, then push into an empty queue
    run_trace(1, 32'h0000_1C00, d_tr, x_tr, o_tr);
    vectors++;
    if (d_tr !== 32'h0000_6000) begin
      miscompares++; $display("FAIL pop_then_push_dout got %h want %h", d_tr, 32'h0000_6000);
    end
    vectors++;
    if (x_tr !== 32'h0) begin
      miscompares++; $display("FAIL pop_then_push_x got %h want %h", x_tr, 32'h0);
    end
  endtask

  task automatic test_negative_pulse();
    logic [31:0] d_tr, x_tr, o_tr;
    run_trace(2, 32'h0000_0400, d_tr, x_tr, o_tr);
    vectors++;
    if ({d_tr, x_tr} !== 64'h0) begin
      miscompares++; $display("FAIL neg_drop got %h want %h", {d_tr, x_tr}, 64'h0);
    end
    run_trace(3, 32'h0000_0400, d_tr, x_tr, o_tr);
    vectors++;
    if (x_tr !== 32'h0000_3000) begin
      miscompares++; $display("FAIL neg_show_x got %h want %h", x_tr, 32'h0000_3000);
    end
    vectors++;
    if (d_tr !== 32'h0) begin
      miscompares++; $display("FAIL neg_show_dout got %h want %h", d_tr, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d_tr, x_tr, o_tr;
    // edges at 10..14: four queued, the fifth overflows; the dropped rise leaves dout at 0
    run_trace(4, 32'hFFFF_D400, d_tr, x_tr, o_tr);
    vectors++;
    if (o_tr !== 32'hFFFF_C000) begin
      miscompares++; $display("FAIL ovf_trace got %h want %h", o_tr, 32'hFFFF_C000);
    end
    vectors++;
    if (d_tr !== 32'h0014_0000) begin
      miscompares++; $display("FAIL b2b_dout got %h want %h", d_tr, 32'h0014_0000);
    end
    vectors++;
    if (x_tr !== 32'h0) begin
      miscompares++; $display("FAIL b2b_x got %h want %h", x_tr, 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] pat;
    logic       seen;
    pat = 5'b10101;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      din[4] = (c <= 5) ? pat[c-1] : 1'b1;
      @(posedge clk);
      #1;
    end
    vectors++;
    if ({ovf[4], dout[4]} !== 2'b10) begin
      miscompares++; $display("FAIL mid_pre_reset got %b want 10", {ovf[4], dout[4]});
    end
    #2 rst_n = 1'b0;
    din = '0;
    #1;
    vectors++;
    if ({dout, dout_x, ovf} !== 15'h0) begin
      miscompares++; $display("FAIL mid_async_clear got %h want 0000", {dout, dout_x, ovf});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      seen = seen | dout[4] | dout_x[4] | ovf[4];
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++; $display("FAIL mid_no_late_event got %b want 0", seen);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    din   = '0;
    test_reset();
    test_rise_hold();
    test_wide_pulse();
    test_narrow_pulse();
    test_x_window();
    test_negative_pulse();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
